// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU funct/ALUConf encodings, MD-unit funct codes,
// MD-unit FSM states and divide-by-zero result convention.
package cpu_pkg;

    typedef enum logic [5:0] {
        ALU_F_SLL  = 6'h00,
        ALU_F_SRL  = 6'h02,
        ALU_F_SRA  = 6'h03,
        ALU_F_ADD  = 6'h20,
        ALU_F_ADDU = 6'h21,
        ALU_F_SUB  = 6'h22,
        ALU_F_SUBU = 6'h23,
        ALU_F_AND  = 6'h24,
        ALU_F_OR   = 6'h25,
        ALU_F_XOR  = 6'h26,
        ALU_F_NOR  = 6'h27,
        ALU_F_SLT  = 6'h2a,
        ALU_F_SLTU = 6'h2b
    } alu_funct_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_conf_e;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIN  = 2'd2
    } md_state_e;

    // Divide by zero: every quotient bit reads as this value, remainder = dividend.
    localparam logic DIV0_QUOT_BIT = 1'b1;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply and restoring
// divide on unsigned magnitudes sharing one adder, sign correction on the output.
module mdu_core
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_a_orig;
    logic               r_div;
    logic               r_div0;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add_a;
    logic [WIDTH:0]     w_add_b;
    logic [WIDTH:0]     w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_a_neg = i_signed & i_op_a[WIDTH-1];
        w_b_neg = i_signed & i_op_b[WIDTH-1];
        w_mag_a = w_a_neg ? -i_op_a : i_op_a;
        w_mag_b = w_b_neg ? -i_op_b : i_op_b;
    end

    // Multiply adds the multiplicand to the running high half; divide subtracts
    // the divisor from the shifted partial remainder (carry-out = no borrow).
    always_comb begin
        w_add_a = r_div ? {r_acc, r_q[WIDTH-1]} : {1'b0, r_acc};
        w_add_b = r_div ? ~{1'b0, r_b} : {1'b0, r_b};
        {w_cout, w_sum} = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(WIDTH+1){1'b0}}, r_div};
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_div    <= i_is_div;
            r_div0   <= i_is_div && (i_op_b == '0);
            r_a_orig <= i_op_a;
            r_acc    <= '0;
            r_q      <= i_is_div ? w_mag_a : w_mag_b;
            r_b      <= i_is_div ? w_mag_b : w_mag_a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= i_is_div ? w_a_neg : (w_a_neg ^ w_b_neg);
        end else if (i_step) begin
            if (r_div) begin
                if (w_cout) begin
                    r_acc <= w_sum[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= w_add_a[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else if (r_q[0]) begin
                r_acc <= w_sum[WIDTH:1];
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end else begin
                r_acc <= {1'b0, r_acc[WIDTH-1:1]};
                r_q   <= {r_acc[0], r_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        w_prod = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
        if (!r_div) begin
            o_hi = w_prod[2*WIDTH-1:WIDTH];
            o_lo = w_prod[WIDTH-1:0];
        end else if (r_div0) begin
            o_hi = r_a_orig;
            o_lo = {WIDTH{DIV0_QUOT_BIT}};
        end else begin
            o_hi = r_neg_r ? -r_acc : r_acc;
            o_lo = r_neg_q ? -r_q : r_q;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO multiply-divide unit: control FSM, HI/LO registers and mthi/mtlo,
// driving the iterative mdu_core datapath.
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned    CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    md_state_e        r_state;
    md_state_e        w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic             w_req;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_accept_md;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_step;
    logic             w_commit;

    // Abort outranks start, so a flushed request is never accepted.
    always_comb begin
        w_req       = start && !abort && (r_state == MD_IDLE);
        w_is_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
        w_is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            MD_IDLE: if (w_req && is_md_funct(funct)) w_next = MD_CALC;
            MD_CALC: begin
                if (abort)                   w_next = MD_IDLE;
                else if (r_cnt == LAST_STEP) w_next = MD_FIN;
            end
            MD_FIN:  w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != MD_IDLE);
        w_accept_md = w_req && is_md_funct(funct);
        w_mthi      = w_req && (funct == FUNCT_MTHI);
        w_mtlo      = w_req && (funct == FUNCT_MTLO);
        w_step      = (r_state == MD_CALC);
        w_commit    = (r_state == MD_FIN) && !abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= w_commit;
            r_cnt  <= (w_step && !abort) ? r_cnt + CW'(1) : '0;
            if (w_commit) begin
                r_hi <= w_core_hi;
                r_lo <= w_core_lo;
            end else begin
                if (w_mthi) r_hi <= op_a;
                if (w_mtlo) r_lo <= op_a;
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .i_load   (w_accept_md),
        .i_step   (w_step),
        .i_is_div (w_is_div),
        .i_signed (w_is_signed),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32; operand/HI/LO width; even, >=8.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request valid this cycle.
REQ-005 SHALL have port funct  in  6  MIPS funct: 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu, 0x11 mthi, 0x13 mtlo.
REQ-006 SHALL have port op_a  in  WIDTH  rs value (multiplicand/dividend/mthi-mtlo source).
REQ-007 SHALL have port op_b  in  WIDTH  rt value (multiplier/divisor).
REQ-008 SHALL have port abort  in  1  pipeline flush; cancels in-flight operation.
REQ-009 SHALL have port busy  out  1  operation in flight; pipeline stalls mfhi/mflo/new md ops.
REQ-010 SHALL have port done  out  1  one-cycle pulse: HI/LO just updated by mult/div.
REQ-011 SHALL have port hi  out  WIDTH  HI register.
REQ-012 SHALL have port lo  out  WIDTH  LO register.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIN -> IDLE; busy=1 in CALC and FIN only.
REQ-014 SHALL accept start only in IDLE; start in CALC/FIN ignored, no state change.
REQ-015 SHALL, on accepted mult/multu/div/divu, latch operands, signedness, op type; enter CALC next edge.
REQ-016 SHALL iterate radix-2 (shift-add multiply, restoring divide) one bit per cycle, CALC lasting exactly WIDTH cycles, counter width clog2(WIDTH)+1.
REQ-017 SHALL spend one FIN cycle applying sign correction; HI/LO written at edge ending FIN.
REQ-018 SHALL assert done for exactly the cycle after FIN; busy=0 that cycle; total latency start-edge to HI/LO visible = WIDTH+2 edges.
REQ-019 SHALL for mult/multu place 2*WIDTH product upper half in HI, lower in LO; signed for mult, unsigned for multu.
REQ-020 SHALL for div/divu place quotient in LO, remainder in HI; signed quotient truncates toward zero, remainder takes dividend's sign.
REQ-021 SHALL on divisor zero (either div) write LO = all ones, HI = op_a, normal latency, done pulsed.
REQ-022 SHALL for signed most-negative / -1 write LO = most-negative, HI = 0, no exception.
REQ-023 SHALL on accepted mthi/mtlo in IDLE write op_a to HI/LO at next edge; no busy, no done.
REQ-024 SHALL ignore start with any other funct.
REQ-025 SHALL on abort in CALC/FIN return to IDLE next edge, HI/LO unchanged, no done.
REQ-026 SHALL give abort priority over start in the same cycle; abort in IDLE is a no-op.
REQ-027 SHALL accept a new start in the cycle done is high.

Reset
REQ-028 SHALL on reset force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of state; reset overrides abort and start.
REQ-029 SHALL, on reset mid-operation, discard partial result; no done afterwards.

Structure
REQ-030 SHALL take funct codes, FSM state encoding, and divide-by-zero result constants from shared package cpu_pkg alongside ALU funct/ALUConf constants.
REQ-031 SHALL split into control FSM (mul_div_unit) and one iterative datapath sub-module mdu_core (shift registers, adder/subtractor, sign fix).
REQ-032 SHALL use no multiplier/divider operators; one WIDTH+1-bit adder shared by both ops.

Verification (WIDTH=32)
REQ-033 SHALL cover multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 34 edges after start, busy=1 for 33 cycles.
REQ-034 SHALL cover mult -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL cover divu 7/0 -> HI=0x00000007, LO=0xFFFFFFFF, done pulsed.
REQ-036 SHALL cover start while busy (second divu 9/3 at cycle 5) -> ignored, first result only; mthi 0x1234 in IDLE -> HI=0x1234 next cycle, busy stays 0.
REQ-037 SHALL cover abort at CALC cycle 10 -> busy=0 next cycle, HI/LO keep prior values, no done; simultaneous abort+start in IDLE -> nothing accepted.
REQ-038 SHALL cover reset at CALC cycle 20 -> hi=lo=0, busy=0 next cycle, no subsequent done.
